// File: rtl/pixel_stream_buffer.sv
// First-word-fall-through pixel FIFO with a line column tracker that flags
// the last pixel of each image line on the output side.
module pixel_stream_buffer #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 16,
  parameter int LINE_WIDTH = 640
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Clear,
  input  logic [DATA_WIDTH-1:0]   InData,
  input  logic                    InValid,
  output logic                    InReady,
  output logic [DATA_WIDTH-1:0]   OutData,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic                    OutLast,
  output logic [$clog2(DEPTH):0]  Count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int COLW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [CW-1:0]   FULL     = CW'(DEPTH);
  localparam logic [COLW-1:0] COL_LAST = COLW'(LINE_WIDTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [COLW-1:0]       col;
  logic                  wr;
  logic                  rd;

  // Handshake flags come from count only, so OutReady never reaches InReady.
  assign InReady  = (count < FULL);
  assign OutValid = (count != '0);
  assign wr       = InValid && InReady;
  assign rd       = OutValid && OutReady;
  assign OutData  = mem[rd_ptr];
  assign OutLast  = OutValid && (col == COL_LAST);
  assign Count    = count;

  always_ff @(posedge Clock) begin
    if (wr && !Clear && !Reset)
      mem[wr_ptr] <= InData;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      col    <= '0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd) begin
        rd_ptr <= rd_ptr + AW'(1);
        col    <= (col == COL_LAST) ? '0 : col + COLW'(1);
      end
      case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_buffer.sv
// Directed bench for pixel_stream_buffer (DEPTH=16, LINE_WIDTH=4) with a queue
// reference that checks flags, data order and line-end marking every cycle.
module tb_pixel_stream_buffer;
  localparam int DW = 24;
  localparam int LW = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Clear = 1'b0;
  logic [DW-1:0] InData = '0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [DW-1:0] OutData;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic          OutLast;
  logic [4:0]    Count;

  pixel_stream_buffer #(.DATA_WIDTH(DW), .DEPTH(16), .LINE_WIDTH(LW)) dut (
    .Clock(Clock), .Reset(Reset), .Clear(Clear),
    .InData(InData), .InValid(InValid), .InReady(InReady),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
    .OutLast(OutLast), .Count(Count)
  );

  always #5 Clock = ~Clock;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] q[$];
  int            mcol = 0;
  int            n_reads = 0;
  logic [31:0]   last_log = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the reference before the edge, then
  // advance the reference and check Count after it.
  task automatic cyc();
    bit mw, mr;
    mw = InValid && (q.size() < 16);
    mr = OutReady && (q.size() != 0);
    chk("in_ready", {31'd0, InReady}, {31'd0, q.size() < 16});
    chk("out_valid", {31'd0, OutValid}, {31'd0, q.size() != 0});
    chk("out_last", {31'd0, OutLast}, {31'd0, (q.size() != 0) && (mcol == LW - 1)});
    if (q.size() != 0) chk("out_data", {8'd0, OutData}, {8'd0, q[0]});
    if (mr && !Reset && !Clear) begin
      if (n_reads < 32) last_log[n_reads] = OutLast;
      n_reads++;
    end
    @(posedge Clock); #1;
    if (Reset || Clear) begin
      q.delete();
      mcol = 0;
    end else begin
      if (mr) begin
        void'(q.pop_front());
        mcol = (mcol == LW - 1) ? 0 : mcol + 1;
      end
      if (mw) q.push_back(InData);
    end
    chk("count", {27'd0, Count}, q.size());
  endtask

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_count", {27'd0, Count}, 32'd0);
    chk("rst_in_ready", {31'd0, InReady}, 32'd1);
    chk("rst_out_valid", {31'd0, OutValid}, 32'd0);
    chk("rst_out_last", {31'd0, OutLast}, 32'd0);
    Reset = 1'b0;

    // three writes, no reads
    InValid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      InData = DW'(i);
      cyc();
    end
    InValid = 1'b0;
    chk("w3_count", {27'd0, Count}, 32'd3);
    chk("w3_out_valid", {31'd0, OutValid}, 32'd1);
    chk("w3_out_data", {8'd0, OutData}, 32'h000001);

    // fill to full, hold a 17th pixel, free one slot
    Clear = 1'b1; cyc(); Clear = 1'b0;
    InValid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      InData = DW'(32'h100 + i);
      cyc();
    end
    chk("full_count", {27'd0, Count}, 32'd16);
    chk("full_in_ready", {31'd0, InReady}, 32'd0);
    InData = 24'hABCDEF;
    cyc();
    chk("held_count", {27'd0, Count}, 32'd16);
    chk("full_head", {8'd0, OutData}, 32'h000100);
    OutReady = 1'b1;
    cyc();
    chk("after_pop_count", {27'd0, Count}, 32'd15);
    chk("after_pop_in_ready", {31'd0, InReady}, 32'd1);
    OutReady = 1'b0;
    cyc();
    chk("held_accepted_count", {27'd0, Count}, 32'd16);
    InValid = 1'b0;
    OutReady = 1'b1;
    repeat (16) cyc();
    chk("drained_count", {27'd0, Count}, 32'd0);
    OutReady = 1'b0;

    // steady state at Count=5 with simultaneous write and read
    Clear = 1'b1; cyc(); Clear = 1'b0;
    InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      InData = DW'(32'h200 + i);
      cyc();
    end
    OutReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      InData = DW'(32'h300 + i);
      cyc();
    end
    chk("steady_count", {27'd0, Count}, 32'd5);
    InValid = 1'b0;
    OutReady = 1'b0;

    // line-end marking over 10 reads
    Clear = 1'b1; cyc(); Clear = 1'b0;
    n_reads = 0;
    last_log = '0;
    OutReady = 1'b1;
    InValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      InData = DW'(32'h400 + i);
      cyc();
    end
    InValid = 1'b0;
    while (OutValid && n_reads < 10) cyc();
    chk("line_reads", n_reads, 32'd10);
    chk("line_last_log", last_log, 32'b0010001000);
    chk("line_col_end", 32'(dut.col), 32'd2);
    OutReady = 1'b0;

    // Clear overrides a concurrent write and read
    Clear = 1'b1; cyc(); Clear = 1'b0;
    InValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      InData = DW'(32'h500 + i);
      cyc();
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    repeat (3) cyc();
    chk("pre_clr_count", {27'd0, Count}, 32'd7);
    chk("pre_clr_col", 32'(dut.col), 32'd3);
    Clear = 1'b1;
    InValid = 1'b1;
    InData = 24'h5A5A5A;
    cyc();
    Clear = 1'b0;
    InValid = 1'b0;
    OutReady = 1'b0;
    chk("clr_count", {27'd0, Count}, 32'd0);
    chk("clr_out_valid", {31'd0, OutValid}, 32'd0);
    chk("clr_col", 32'(dut.col), 32'd0);

    // random push/pop to exercise pointer wrap
    for (int i = 0; i < 40; i++) begin
      InValid = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 1) != 0);
      InData = DW'($urandom);
      cyc();
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    while (OutValid && Count != 0) cyc();
    OutReady = 1'b0;

    // Reset wins over Clear with 9 stored pixels
    InValid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      InData = DW'(32'h600 + i);
      cyc();
    end
    chk("pre_rst_count", {27'd0, Count}, 32'd9);
    Reset = 1'b1;
    Clear = 1'b1;
    OutReady = 1'b1;
    cyc();
    Reset = 1'b0;
    Clear = 1'b0;
    InValid = 1'b0;
    OutReady = 1'b0;
    chk("rc_count", {27'd0, Count}, 32'd0);
    chk("rc_in_ready", {31'd0, InReady}, 32'd1);
    chk("rc_out_valid", {31'd0, OutValid}, 32'd0);
    chk("rc_out_last", {31'd0, OutLast}, 32'd0);

    // after reset the line restarts at column 0
    n_reads = 0;
    last_log = '0;
    InValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      InData = DW'(32'h700 + i);
      cyc();
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    repeat (4) cyc();
    chk("post_rst_last_log", last_log, 32'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
